// File: rtl/vm_word_unpacker.sv
// Word-to-byte unpacker: buffers packed {first, second} words in a small FIFO and
// replays each word as two bytes, high byte first, on a valid/ready byte stream.
module vm_word_unpacker #(
   parameter int DEPTH  = 4,
   parameter int BYTE_W = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [2*BYTE_W-1:0]        in_word,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [BYTE_W-1:0]          out_byte,
   output logic                       out_last,
   output logic [$clog2(DEPTH+1)-1:0] fill_level,
   output logic [15:0]                words_done
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   localparam int WW = 2*BYTE_W;

   typedef enum logic [1:0] {EMPTY, SEND_HI, SEND_LO} state_t;

   logic [WW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr_reg;
   logic [AW-1:0] rd_ptr_reg;
   logic [CW-1:0] count_reg;
   state_t        state_reg;
   logic [WW-1:0] hold_reg;
   logic          out_valid_reg;
   logic [BYTE_W-1:0] out_byte_reg;
   logic          out_last_reg;
   logic [15:0]   words_done_reg;

   logic          push;
   logic          pop;
   logic          have_word;
   logic [WW-1:0] head;

   // Readiness depends only on the registered count, never on out_ready.
   assign in_ready  = (count_reg != CW'(DEPTH));
   assign push      = in_valid && in_ready;
   assign have_word = (count_reg != '0);
   assign pop       = have_word &&
                      ((state_reg == EMPTY) || ((state_reg == SEND_LO) && out_ready));
   assign head      = mem[rd_ptr_reg];

   assign out_valid  = out_valid_reg;
   assign out_byte   = out_byte_reg;
   assign out_last   = out_last_reg;
   assign fill_level = count_reg;
   assign words_done = words_done_reg;

   // Storage array carries no reset so it maps onto plain RAM.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr_reg] <= in_word;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         end
         case ({push, pop})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= EMPTY;
         hold_reg       <= '0;
         out_valid_reg  <= 1'b0;
         out_byte_reg   <= '0;
         out_last_reg   <= 1'b0;
         words_done_reg <= '0;
      end else begin
         case (state_reg)
            EMPTY: begin
               if (have_word) begin
                  hold_reg      <= head;
                  out_valid_reg <= 1'b1;
                  out_byte_reg  <= head[WW-1:BYTE_W];
                  out_last_reg  <= 1'b0;
                  state_reg     <= SEND_HI;
               end
            end
            SEND_HI: begin
               if (out_ready) begin
                  out_byte_reg <= hold_reg[BYTE_W-1:0];
                  out_last_reg <= 1'b1;
                  state_reg    <= SEND_LO;
               end
            end
            SEND_LO: begin
               if (out_ready) begin
                  words_done_reg <= words_done_reg + 16'd1;
                  // Chain straight into the next word so the stream has no bubble.
                  if (have_word) begin
                     hold_reg      <= head;
                     out_byte_reg  <= head[WW-1:BYTE_W];
                     out_last_reg  <= 1'b0;
                     state_reg     <= SEND_HI;
                  end else begin
                     out_valid_reg <= 1'b0;
                     state_reg     <= EMPTY;
                  end
               end
            end
            default: begin
               out_valid_reg <= 1'b0;
               state_reg     <= EMPTY;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_vm_word_unpacker.sv
// Scoreboard bench for vm_word_unpacker: expected bytes are queued when a word is
// accepted and compared when the byte stream hands them off.
module tb_vm_word_unpacker;

   localparam int DEPTH  = 4;
   localparam int BYTE_W = 8;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_word;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  out_byte;
   logic        out_last;
   logic [2:0]  fill_level;
   logic [15:0] words_done;

   vm_word_unpacker #(.DEPTH(DEPTH), .BYTE_W(BYTE_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_word    (in_word),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_byte   (out_byte),
      .out_last   (out_last),
      .fill_level (fill_level),
      .words_done (words_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [8:0]  sb_q[$];
   logic [8:0]  exp_item;
   logic [15:0] exp_words = 16'd0;
   bit          bubble_chk = 0;
   bit          saw_valid  = 0;
   bit          prev_stall = 0;
   logic [7:0]  prev_byte;
   logic        prev_last;

   // Output monitor, sampled on the falling edge while inputs are stable.
   always @(negedge clk) begin
      if (rst) begin
         sb_q.delete();
         exp_words  = 16'd0;
         prev_stall = 0;
         saw_valid  = 0;
      end else begin
         n_checks++;
         if (words_done !== exp_words) begin
            n_fail++;
            $display("FAIL words_done: got %h expected %h", words_done, exp_words);
         end
         if (prev_stall) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_byte !== prev_byte || out_last !== prev_last) begin
               n_fail++;
               $display("FAIL hold_stable: got v=%b b=%h l=%b expected v=1 b=%h l=%b",
                        out_valid, out_byte, out_last, prev_byte, prev_last);
            end
         end
         if (bubble_chk && saw_valid && sb_q.size() > 0) begin
            n_checks++;
            if (out_valid !== 1'b1) begin
               n_fail++;
               $display("FAIL bubble: got out_valid=%b expected 1", out_valid);
            end
         end
         if (out_valid === 1'b1) saw_valid = 1;
         if (out_valid === 1'b1 && out_ready === 1'b1) begin
            n_checks++;
            if (sb_q.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_byte: got b=%h l=%b expected nothing", out_byte, out_last);
            end else begin
               exp_item = sb_q.pop_front();
               if ({out_last, out_byte} !== exp_item) begin
                  n_fail++;
                  $display("FAIL byte: got l=%b b=%h expected l=%b b=%h",
                           out_last, out_byte, exp_item[8], exp_item[7:0]);
               end
               if (exp_item[8]) exp_words = exp_words + 16'd1;
            end
         end
         prev_stall = (out_valid === 1'b1 && out_ready === 1'b0);
         prev_byte  = out_byte;
         prev_last  = out_last;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_word(input logic [15:0] w);
      int budget = 0;
      bit acc = 0;
      in_valid = 1'b1;
      in_word  = w;
      while (!acc && budget < 50) begin
         acc = in_ready;
         if (acc) begin
            sb_q.push_back({1'b0, w[15:8]});
            sb_q.push_back({1'b1, w[7:0]});
         end
         step();
         budget++;
      end
      in_valid = 1'b0;
      n_checks++;
      if (!acc) begin
         n_fail++;
         $display("FAIL push_timeout: word %h got no in_ready expected acceptance", w);
      end
      $display("push word %h accepted=%0d", w, acc);
   endtask

   task automatic drain();
      int budget = 0;
      while ((sb_q.size() > 0 || out_valid === 1'b1) && budget < 100) begin
         step();
         budget++;
      end
      n_checks++;
      if (budget >= 100) begin
         n_fail++;
         $display("FAIL drain_timeout: got %0d bytes pending expected 0", sb_q.size());
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; in_word = '0; out_ready = 1'b0;
      step(); step();
      rst = 1'b0;
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || fill_level !== 3'd0 || words_done !== 16'd0) begin
         n_fail++;
         $display("FAIL reset_init: got v=%b rdy=%b fill=%0d wd=%h expected 0 1 0 0",
                  out_valid, in_ready, fill_level, words_done);
      end
      // Load traffic, then reset mid-word.
      push_word(16'hDEAD);
      push_word(16'hBEEF);
      push_word(16'hCAFE);
      step();
      rst = 1'b1;
      step(); step();
      rst = 1'b0;
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || fill_level !== 3'd0 || words_done !== 16'd0) begin
         n_fail++;
         $display("FAIL reset_mid: got v=%b rdy=%b fill=%0d wd=%h expected 0 1 0 0",
                  out_valid, in_ready, fill_level, words_done);
      end
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         step();
         n_checks++;
         if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flush: got out_valid=%b expected 0", out_valid);
         end
      end
      $display("test_reset done");
   endtask

   task automatic test_single();
      out_ready = 1'b1;
      push_word(16'hA55A);
      n_checks++;
      if (out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL single_bypass: got out_valid=%b expected 0", out_valid);
      end
      step();
      n_checks++;
      if (out_valid !== 1'b1 || out_byte !== 8'hA5 || out_last !== 1'b0) begin
         n_fail++;
         $display("FAIL single_hi: got v=%b b=%h l=%b expected 1 a5 0", out_valid, out_byte, out_last);
      end
      step();
      n_checks++;
      if (out_valid !== 1'b1 || out_byte !== 8'h5A || out_last !== 1'b1) begin
         n_fail++;
         $display("FAIL single_lo: got v=%b b=%h l=%b expected 1 5a 1", out_valid, out_byte, out_last);
      end
      step();
      n_checks++;
      if (out_valid !== 1'b0 || words_done !== 16'd1) begin
         n_fail++;
         $display("FAIL single_done: got v=%b wd=%h expected 0 0001", out_valid, words_done);
      end
      $display("test_single done");
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      push_word(16'h1234);
      step();
      for (int i = 0; i < 5; i++) begin
         n_checks++;
         if (out_valid !== 1'b1 || out_byte !== 8'h12 || out_last !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_hold: got v=%b b=%h l=%b expected 1 12 0", out_valid, out_byte, out_last);
         end
         step();
      end
      out_ready = 1'b1;
      step();
      n_checks++;
      if (out_valid !== 1'b1 || out_byte !== 8'h34 || out_last !== 1'b1) begin
         n_fail++;
         $display("FAIL bp_lo: got v=%b b=%h l=%b expected 1 34 1", out_valid, out_byte, out_last);
      end
      drain();
      $display("test_backpressure done");
   endtask

   task automatic test_full();
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) push_word(16'hC000 + 16'(i));
      n_checks++;
      if (fill_level !== 3'd4 || in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL full_level: got fill=%0d rdy=%b expected 4 0", fill_level, in_ready);
      end
      in_valid = 1'b1;
      in_word  = 16'hC005;
      for (int i = 0; i < 3; i++) begin
         step();
         n_checks++;
         if (fill_level !== 3'd4 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL full_stall: got fill=%0d rdy=%b expected 4 0", fill_level, in_ready);
         end
      end
      out_ready = 1'b1;
      push_word(16'hC005);
      drain();
      $display("test_full done");
   endtask

   task automatic test_streaming();
      out_ready  = 1'b1;
      saw_valid  = 0;
      bubble_chk = 1;
      for (int i = 1; i <= 8; i++) push_word(16'(i));
      drain();
      bubble_chk = 0;
      n_checks++;
      if (words_done !== 16'd16) begin
         n_fail++;
         $display("FAIL stream_count: got wd=%h expected 0010", words_done);
      end
      $display("test_streaming done");
   endtask

   task automatic test_wrap();
      out_ready = 1'b0;
      force dut.words_done_reg = 16'hFFFF;
      exp_words = 16'hFFFF;
      step();
      release dut.words_done_reg;
      step();
      out_ready = 1'b1;
      push_word(16'hBEEF);
      drain();
      n_checks++;
      if (words_done !== 16'd0) begin
         n_fail++;
         $display("FAIL wrap: got wd=%h expected 0000", words_done);
      end
      $display("test_wrap done");
   endtask

   initial begin
      test_reset();
      test_single();
      test_backpressure();
      test_full();
      test_streaming();
      test_wrap();
      step();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no completion expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule
